track_volume_ctrl: RTL and testbench
====================================

Name: track_volume_ctrl

Overview:
- Sits directly downstream of the Bluetooth command decoder.
- Consumes its level-style PREV[2:0]/NEXT[2:0] skip counts and UP/DOWN flags, and turns them into discrete events.
- Maintains the current track index (with wrap-around) and the volume level (with saturation and hold-to-repeat).
- Hands volume words to the MP3 decoder SCI driver over a req/ack handshake.

Parameters:
- NUM_TRACKS, 8, number of tracks; legal range 8..64, so that one conditional add or subtract of NUM_TRACKS handles any skip of 0..7.
- VOL_MAX, 15, highest volume level; level 0 is quietest.
- VOL_INIT, 10, volume level after reset.
- VOL_STEP, 8, attenuation units (0.5 dB each) per level.
- REPEAT_DELAY, 50_000_000, cycles UP/DOWN must be held before the first auto-repeat (0.5 s at 100 MHz).
- REPEAT_PERIOD, 20_000_000, cycles between subsequent auto-repeats.

Ports:
- CLK  in  1  system clock, 100 MHz.
- RST  in  1  asynchronous, active-high reset.
- PREV  in  3  skip-backward count from the command decoder; a level, held while the same byte persists.
- NEXT  in  3  skip-forward count; a level.
- UP  in  1  volume-up request; a level.
- DOWN  in  1  volume-down request; a level.
- SONG_DONE  in  1  one-cycle pulse from the playback engine at end of file.
- TRACK  out  TRK_W  current track index; TRK_W = clog2(NUM_TRACKS).
- TRACK_CHG  out  1  one-cycle pulse when TRACK changes.
- VOL_LEVEL  out  4  current volume level.
- VOL_WORD  out  16  SCI_VOL value {att,att}.
- VOL_REQ  out  1  new VOL_WORD is pending.
- VOL_ACK  in  1  SCI driver has consumed VOL_WORD.

Behaviour:
- Reset values:
  - TRACK = 0, TRACK_CHG = 0.
  - VOL_LEVEL = VOL_INIT, VOL_WORD = word(VOL_INIT), VOL_REQ = 0.
  - All edge and repeat state cleared.
- Inputs are registered once; previous-sample registers hold {PREV,NEXT}, UP and DOWN.
- Track command event:
  - Occurs when the registered {PREV,NEXT} differs from its previous sample and the new value is nonzero.
  - The same byte sent twice in a row produces no second event; this is intentional.
- Track arithmetic, applied one cycle after the event:
  - PREV = k ≠ 0: TRACK = TRACK − k; if the result would be negative, add NUM_TRACKS.
  - Else NEXT = k ≠ 0: TRACK = TRACK + k; if the result is ≥ NUM_TRACKS, subtract NUM_TRACKS.
  - Compute in TRK_W+1 bits.
  - PREV has priority if both are nonzero.
- SONG_DONE: TRACK = TRACK + 1, with wrap from NUM_TRACKS−1 to 0. If a track command event occurs in the same cycle, the command wins and SONG_DONE is dropped.
- TRACK_CHG:
  - Pulses high for exactly one cycle, coincident with the cycle TRACK takes its new value.
  - Not asserted when the computed value equals the old one, i.e. k = NUM_TRACKS, which is impossible in the legal range.
- Volume step:
  - A rising edge of UP with DOWN low gives +1.
  - A rising edge of DOWN with UP low gives −1.
  - UP and DOWN high together: no step, and both repeat counters clear.
  - Level saturates at 0 and VOL_MAX; a saturated step produces no change and no request.
- Hold-to-repeat:
  - While the input stays high alone, a counter runs.
  - At REPEAT_DELAY cycles after the edge it issues one step, then one every REPEAT_PERIOD.
  - A low input clears the counter.
- Attenuation: att = (VOL_MAX − VOL_LEVEL) × VOL_STEP, clamped to 0xFE. VOL_WORD = {att, att}.
- Handshake:
  - On a level change with VOL_REQ low, VOL_WORD is updated and VOL_REQ rises the next cycle.
  - VOL_WORD is stable while VOL_REQ is high.
  - A change while VOL_REQ is high updates VOL_LEVEL only and sets a dirty flag.
  - VOL_ACK high while VOL_REQ high drops VOL_REQ next cycle.
  - If dirty, VOL_REQ then reasserts with the latest word after exactly one low cycle.
  - VOL_ACK while VOL_REQ is low is ignored.
- Reset mid-operation: asynchronous clear of all state; any pending request is discarded, and no request is issued after reset.

Decomposition:
- Shared package holds:
  - The SCI_VOL word layout: left byte [15:8], right byte [7:0].
  - The 0xFE attenuation clamp.
  - Default timing constants derived from the 100 MHz CLK.
- One sub-module, hold_repeat:
  - Ports: CLK, RST, IN, CLR, STEP.
  - Performs edge detection, the delay counter and the period counter.
  - Instantiated twice, once for UP and once for DOWN.

Test Plan:
- Reset, then hold NEXT = 3 → TRACK 0→3 with one TRACK_CHG pulse. Keep NEXT = 3 for 1000 cycles → no further change. Drop to 0, then NEXT = 3 again → TRACK = 6.
- TRACK = 6, PREV = 7 → TRACK = 7 (wrap, NUM_TRACKS = 8). SONG_DONE with TRACK = 7 → TRACK = 0.
- SONG_DONE in the same cycle as a NEXT = 2 event with TRACK = 1 → TRACK = 3 and only one TRACK_CHG.
- VOL_INIT = 10, UP pulse → VOL_LEVEL = 11, VOL_WORD = 0x2020, VOL_REQ high until VOL_ACK. Step to 15 → VOL_WORD = 0x0000, and a further UP gives no request.
- Hold DOWN (REPEAT_DELAY = 100, REPEAT_PERIOD = 20 in bench) for 165 cycles → steps at edge, +100, +120, +140, +160 (level 10→5). Hold UP and DOWN together → no step.
- Raise VOL_REQ, issue two more steps before VOL_ACK → VOL_WORD unchanged until ack. VOL_REQ is low one cycle after ack, then reasserts with the final word. Assert RST mid-pending → VOL_REQ = 0 and no later request.

Source files
------------

// File: rtl/track_volume_ctrl_pkg.sv
// track_volume_ctrl_pkg: shared SCI_VOL word layout, attenuation clamp and default timing.
// No ports; imported by the track/volume controller files.
package track_volume_ctrl_pkg;
    localparam int CLK_HZ = 100_000_000;
    localparam int DEF_REPEAT_DELAY = CLK_HZ / 2;
    localparam int DEF_REPEAT_PERIOD = CLK_HZ / 5;
    localparam logic [7:0] ATT_CLAMP = 8'hFE;
    typedef struct packed {
        logic [7:0] left;
        logic [7:0] right;
    } sci_vol_t;
    function automatic sci_vol_t att_word(input logic [3:0] lvl, input int vol_max, input int vol_step);
        int att;
        logic [7:0] a;
        att = (vol_max - int'(lvl)) * vol_step;
        a = att > int'(ATT_CLAMP) ? ATT_CLAMP : 8'(att);
        return '{left: a, right: a};
    endfunction
endpackage

// File: rtl/track_volume_ctrl_if.sv
// track_volume_ctrl_if: command, status and SCI volume handshake signals of the controller.
// master drives commands/ack and observes status; slave is the controller.
interface track_volume_ctrl_if #(parameter int TRK_W = 3);
    logic [2:0] prev;
    logic [2:0] next;
    logic up;
    logic down;
    logic song_done;
    logic [TRK_W-1:0] track;
    logic track_chg;
    logic [3:0] vol_level;
    logic [15:0] vol_word;
    logic vol_req;
    logic vol_ack;
    modport master(output prev, next, up, down, song_done, vol_ack,
                   input track, track_chg, vol_level, vol_word, vol_req);
    modport slave(input prev, next, up, down, song_done, vol_ack,
                  output track, track_chg, vol_level, vol_word, vol_req);
endinterface

// File: rtl/track_volume_ctrl_hold_repeat.sv
// track_volume_ctrl_hold_repeat: edge step plus hold-to-repeat steps for one button level.
// Ports: clk, rst (async high), in (button level), clr (cancel/clear counter), step (1-cycle step).
module track_volume_ctrl_hold_repeat #(
    parameter int REPEAT_DELAY = 50_000_000,
    parameter int REPEAT_PERIOD = 20_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    input  logic clr,
    output logic step
);
    localparam int CW = $clog2((REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD) + 1);
    logic in_d, rep, edge_ev, due;
    logic [CW-1:0] cnt;
    assign edge_ev = in & ~in_d;
    assign due = cnt == (rep ? CW'(REPEAT_PERIOD) : CW'(REPEAT_DELAY));
    assign step = in & ~clr & (edge_ev | due);
    // cnt = cycles since the last step; zero means idle, so a cleared hold never resumes without a new edge
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            in_d <= 1'b0;
            rep <= 1'b0;
            cnt <= '0;
        end else begin
            in_d <= in;
            if (!in || clr) begin
                cnt <= '0;
                rep <= 1'b0;
            end else if (step) begin
                cnt <= CW'(1);
                rep <= ~edge_ev;
            end else if (cnt != '0) cnt <= cnt + CW'(1);
        end
endmodule

// File: rtl/track_volume_ctrl.sv
// track_volume_ctrl: turns decoder skip/volume levels into track index and volume updates.
// Ports: clk, rst (async high), bus (slave): prev/next/up/down/song_done in, track/track_chg,
// vol_level/vol_word/vol_req out, vol_ack in.
module track_volume_ctrl
    import track_volume_ctrl_pkg::*;
#(
    parameter int NUM_TRACKS = 8,
    parameter int VOL_MAX = 15,
    parameter int VOL_INIT = 10,
    parameter int VOL_STEP = 8,
    parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input logic clk,
    input logic rst,
    track_volume_ctrl_if.slave bus
);
    localparam int TRK_W = $clog2(NUM_TRACKS);
    logic [2:0] prev_r, next_r;
    logic [5:0] cmd_d;
    logic up_r, down_r, song_r, cmd_ev, both, step_up, step_dn, vol_chg, dirty, track_chg, vol_req;
    logic [TRK_W-1:0] track, trk_nxt, back_w, fwd_w, inc_w;
    logic [TRK_W:0] t_ext, back, fwd;
    logic [3:0] vol_level, lvl_nxt;
    sci_vol_t vol_word;
    assign cmd_ev = {prev_r, next_r} != cmd_d && {prev_r, next_r} != 6'd0;
    // one extra bit shows the borrow / overflow that triggers a single wrap correction
    assign t_ext = {1'b0, track};
    assign back = t_ext - (TRK_W+1)'(prev_r);
    assign fwd = t_ext + (TRK_W+1)'(next_r);
    assign back_w = back[TRK_W] ? TRK_W'(back + (TRK_W+1)'(NUM_TRACKS)) : back[TRK_W-1:0];
    assign fwd_w = fwd >= (TRK_W+1)'(NUM_TRACKS) ? TRK_W'(fwd - (TRK_W+1)'(NUM_TRACKS)) : fwd[TRK_W-1:0];
    assign inc_w = track == TRK_W'(NUM_TRACKS - 1) ? '0 : track + TRK_W'(1);
    assign trk_nxt = cmd_ev ? (prev_r != 3'd0 ? back_w : fwd_w) : song_r ? inc_w : track;
    assign both = up_r & down_r;
    track_volume_ctrl_hold_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD))
        u_up (.clk(clk), .rst(rst), .in(up_r), .clr(both), .step(step_up));
    track_volume_ctrl_hold_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD))
        u_dn (.clk(clk), .rst(rst), .in(down_r), .clr(both), .step(step_dn));
    assign lvl_nxt = step_up && vol_level != 4'(VOL_MAX) ? vol_level + 4'd1 :
                     step_dn && vol_level != 4'd0 ? vol_level - 4'd1 : vol_level;
    assign vol_chg = lvl_nxt != vol_level;
    assign bus.track = track;
    assign bus.track_chg = track_chg;
    assign bus.vol_level = vol_level;
    assign bus.vol_word = vol_word;
    assign bus.vol_req = vol_req;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            prev_r <= '0;
            next_r <= '0;
            cmd_d <= '0;
            up_r <= 1'b0;
            down_r <= 1'b0;
            song_r <= 1'b0;
            track <= '0;
            track_chg <= 1'b0;
            vol_level <= 4'(VOL_INIT);
            vol_word <= att_word(4'(VOL_INIT), VOL_MAX, VOL_STEP);
            vol_req <= 1'b0;
            dirty <= 1'b0;
        end else begin
            prev_r <= bus.prev;
            next_r <= bus.next;
            cmd_d <= {prev_r, next_r};
            up_r <= bus.up;
            down_r <= bus.down;
            song_r <= bus.song_done;
            track <= trk_nxt;
            track_chg <= trk_nxt != track;
            vol_level <= lvl_nxt;
            // word is frozen while a request is pending; a dirty flag forces one low cycle then a resend
            if (vol_req) begin
                if (bus.vol_ack) vol_req <= 1'b0;
                if (vol_chg) dirty <= 1'b1;
            end else if (vol_chg || dirty) begin
                vol_word <= att_word(lvl_nxt, VOL_MAX, VOL_STEP);
                vol_req <= 1'b1;
                dirty <= 1'b0;
            end
        end
endmodule

// File: tb/tb_track_volume_ctrl.sv
// tb_track_volume_ctrl: table-driven track vectors plus hand-written volume/handshake sequences.
module tb_track_volume_ctrl;
    logic clk = 1'b0;
    logic rst;
    int checks = 0;
    int errors = 0;
    int pulses = 0;
    logic mon_en = 1'b0;
    logic [2:0] last_track = '0;

    typedef struct {
        logic [2:0] prev;
        logic [2:0] next;
        logic song;
        int cycles;
        logic [2:0] exp_track;
        int exp_pulses;
    } trk_vec_t;
    trk_vec_t vecs[14];

    track_volume_ctrl_if #(.TRK_W(3)) bus();
    track_volume_ctrl #(
        .NUM_TRACKS(8), .VOL_MAX(15), .VOL_INIT(10), .VOL_STEP(8),
        .REPEAT_DELAY(100), .REPEAT_PERIOD(20)
    ) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_up();
        bus.up = 1'b1;
        cyc(1);
        bus.up = 1'b0;
        cyc(3);
    endtask

    task automatic ack();
        bus.vol_ack = 1'b1;
        cyc(1);
        bus.vol_ack = 1'b0;
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(1);
        mon_en = 1'b1;
    endtask

    // TRACK_CHG must be high exactly in the cycles where TRACK differs from the cycle before
    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            check("chg_coincide", {31'd0, bus.track_chg}, {31'd0, bus.track != last_track});
            pulses += int'(bus.track_chg);
        end
        last_track = bus.track;
    end

    initial begin
        rst = 1'b1;
        bus.prev = '0;
        bus.next = '0;
        bus.up = 1'b0;
        bus.down = 1'b0;
        bus.song_done = 1'b0;
        bus.vol_ack = 1'b0;
        vecs[0]  = '{3'd0, 3'd3, 1'b0, 5,    3'd3, 1};
        vecs[1]  = '{3'd0, 3'd3, 1'b0, 1000, 3'd3, 0};
        vecs[2]  = '{3'd0, 3'd0, 1'b0, 5,    3'd3, 0};
        vecs[3]  = '{3'd0, 3'd3, 1'b0, 5,    3'd6, 1};
        vecs[4]  = '{3'd0, 3'd0, 1'b0, 5,    3'd6, 0};
        vecs[5]  = '{3'd7, 3'd0, 1'b0, 5,    3'd7, 1};
        vecs[6]  = '{3'd0, 3'd0, 1'b0, 5,    3'd7, 0};
        vecs[7]  = '{3'd0, 3'd0, 1'b1, 5,    3'd0, 1};
        vecs[8]  = '{3'd0, 3'd0, 1'b1, 5,    3'd1, 1};
        vecs[9]  = '{3'd0, 3'd2, 1'b1, 5,    3'd3, 1};
        vecs[10] = '{3'd5, 3'd0, 1'b0, 5,    3'd6, 1};
        vecs[11] = '{3'd5, 3'd2, 1'b0, 5,    3'd1, 1};
        vecs[12] = '{3'd0, 3'd0, 1'b0, 5,    3'd1, 0};
        vecs[13] = '{3'd0, 3'd7, 1'b0, 5,    3'd0, 1};
        do_reset();
        check("rst_track", {29'd0, bus.track}, 32'd0);
        check("rst_track_chg", {31'd0, bus.track_chg}, 32'd0);
        check("rst_vol_level", {28'd0, bus.vol_level}, 32'd10);
        check("rst_vol_word", {16'd0, bus.vol_word}, 32'h2828);
        check("rst_vol_req", {31'd0, bus.vol_req}, 32'd0);
        for (int i = 0; i < 14; i++) begin
            bus.prev = vecs[i].prev;
            bus.next = vecs[i].next;
            bus.song_done = vecs[i].song;
            pulses = 0;
            cyc(1);
            bus.song_done = 1'b0;
            cyc(vecs[i].cycles - 1);
            check($sformatf("vec%0d_track", i), {29'd0, bus.track}, {29'd0, vecs[i].exp_track});
            check($sformatf("vec%0d_pulses", i), pulses, vecs[i].exp_pulses);
        end
        bus.prev = '0;
        bus.next = '0;
        pulse_up();
        check("up_level", {28'd0, bus.vol_level}, 32'd11);
        check("up_word", {16'd0, bus.vol_word}, 32'h2020);
        check("up_req", {31'd0, bus.vol_req}, 32'd1);
        cyc(5);
        check("up_req_held", {31'd0, bus.vol_req}, 32'd1);
        ack();
        check("ack_drop", {31'd0, bus.vol_req}, 32'd0);
        cyc(5);
        check("ack_stays_low", {31'd0, bus.vol_req}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            pulse_up();
            ack();
        end
        check("max_level", {28'd0, bus.vol_level}, 32'd15);
        check("max_word", {16'd0, bus.vol_word}, 32'h0000);
        pulse_up();
        cyc(2);
        check("sat_level", {28'd0, bus.vol_level}, 32'd15);
        check("sat_no_req", {31'd0, bus.vol_req}, 32'd0);
        bus.vol_ack = 1'b1;
        cyc(3);
        bus.vol_ack = 1'b0;
        cyc(1);
        check("idle_ack_ignored", {31'd0, bus.vol_req}, 32'd0);
        do_reset();
        check("rst2_level", {28'd0, bus.vol_level}, 32'd10);
        bus.down = 1'b1;
        cyc(50);
        check("hold_edge_level", {28'd0, bus.vol_level}, 32'd9);
        check("hold_edge_word", {16'd0, bus.vol_word}, 32'h3030);
        check("hold_edge_req", {31'd0, bus.vol_req}, 32'd1);
        cyc(115);
        bus.down = 1'b0;
        cyc(3);
        check("hold_end_level", {28'd0, bus.vol_level}, 32'd5);
        check("hold_word_frozen", {16'd0, bus.vol_word}, 32'h3030);
        check("hold_req_high", {31'd0, bus.vol_req}, 32'd1);
        ack();
        check("dirty_low_cycle", {31'd0, bus.vol_req}, 32'd0);
        cyc(1);
        check("dirty_reassert", {31'd0, bus.vol_req}, 32'd1);
        check("dirty_word", {16'd0, bus.vol_word}, 32'h5050);
        ack();
        cyc(3);
        check("clean_low", {31'd0, bus.vol_req}, 32'd0);
        bus.up = 1'b1;
        bus.down = 1'b1;
        cyc(150);
        check("both_level", {28'd0, bus.vol_level}, 32'd5);
        check("both_req", {31'd0, bus.vol_req}, 32'd0);
        bus.up = 1'b0;
        bus.down = 1'b0;
        cyc(3);
        check("both_release_level", {28'd0, bus.vol_level}, 32'd5);
        pulse_up();
        check("pend_level", {28'd0, bus.vol_level}, 32'd6);
        check("pend_word", {16'd0, bus.vol_word}, 32'h4848);
        pulse_up();
        pulse_up();
        check("pend2_level", {28'd0, bus.vol_level}, 32'd8);
        check("pend2_word", {16'd0, bus.vol_word}, 32'h4848);
        check("pend2_req", {31'd0, bus.vol_req}, 32'd1);
        mon_en = 1'b0;
        rst = 1'b1;
        #1;
        check("async_rst_req", {31'd0, bus.vol_req}, 32'd0);
        check("async_rst_level", {28'd0, bus.vol_level}, 32'd10);
        check("async_rst_word", {16'd0, bus.vol_word}, 32'h2828);
        cyc(2);
        rst = 1'b0;
        mon_en = 1'b1;
        cyc(200);
        check("post_rst_no_req", {31'd0, bus.vol_req}, 32'd0);
        check("post_rst_level", {28'd0, bus.vol_level}, 32'd10);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
